// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: send one byte, await ACK/RESEND/ERROR with retries and timeouts.
// Optional macro PS2_AUTO_INIT_EN: issue 0xFF after reset and wait for the 0xAA BAT result.
module ps2_cmd_sequencer #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 200000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic [1:0] cmd_err,
    output logic       tx_send,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    input  logic       rx_word_ready,
    input  logic [7:0] rx_byte,
    output logic       scan_valid,
    output logic [7:0] scan_byte
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SEND      = 4'd1,
        ST_WAIT_BUSY = 4'd2,
        ST_WAIT_TX   = 4'd3,
        ST_WAIT_ACK  = 4'd4,
        ST_DONE      = 4'd5,
        ST_FAIL      = 4'd6,
        ST_INIT      = 4'd7,
        ST_WAIT_BAT  = 4'd8
    } state_t;

    localparam logic [19:0] TIMEOUT_C   = 20'(TIMEOUT);
    localparam logic [1:0]  RETRY_MAX_C = 2'(MAX_RETRY);
    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]  ERR_RETRY   = 2'b10;
    localparam logic [1:0]  ERR_DEVICE  = 2'b11;

`ifdef PS2_AUTO_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [19:0] r_timer;
    logic [1:0]  r_retry;
    logic        r_init;
    logic        r_cmd_ready;
    logic        r_cmd_done;
    logic [1:0]  r_cmd_err;
    logic        r_tx_send;
    logic [7:0]  r_tx_byte;
    logic        r_scan_valid;
    logic [7:0]  r_scan_byte;

    logic        w_timeout;
    logic        w_timer_clr;
    logic        w_retry_clr;
    logic        w_retry_inc;
    logic        w_load_cmd;
    logic        w_load_init;
    logic        w_init_set;
    logic        w_init_clr;
    logic        w_fwd;
    logic        w_done;
    logic [1:0]  w_err;

    assign w_timeout = (r_timer == TIMEOUT_C);

    // Next-state and control decode; a received byte always takes priority over a timeout.
    always_comb begin
        w_state_next = r_state;
        w_timer_clr  = 1'b0;
        w_retry_clr  = 1'b0;
        w_retry_inc  = 1'b0;
        w_load_cmd   = 1'b0;
        w_load_init  = 1'b0;
        w_init_set   = 1'b0;
        w_init_clr   = 1'b0;
        w_fwd        = 1'b0;
        w_done       = 1'b0;
        w_err        = ERR_OK;
        case (r_state)
            ST_IDLE: begin
                w_fwd = rx_word_ready;
                if (cmd_valid && r_cmd_ready) begin
                    w_load_cmd   = 1'b1;
                    w_retry_clr  = 1'b1;
                    w_state_next = ST_SEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_INIT: begin
                w_load_init  = 1'b1;
                w_retry_clr  = 1'b1;
                w_init_set   = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                w_timer_clr  = 1'b1;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                w_fwd = rx_word_ready && !r_init;
                if (tx_busy) begin
                    w_state_next = ST_WAIT_TX;
                end else if (w_timeout) begin
                    w_done       = 1'b1;
                    w_err        = ERR_TIMEOUT;
                    w_state_next = ST_FAIL;
                end else begin
                    w_state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_TX: begin
                w_fwd = rx_word_ready && !r_init;
                if (!tx_busy) begin
                    w_timer_clr  = 1'b1;
                    w_state_next = ST_WAIT_ACK;
                end else if (w_timeout) begin
                    w_done       = 1'b1;
                    w_err        = ERR_TIMEOUT;
                    w_state_next = ST_FAIL;
                end else begin
                    w_state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_word_ready) begin
                    case (rx_byte)
                        8'hFA: begin
                            if (r_init) begin
                                w_timer_clr  = 1'b1;
                                w_state_next = ST_WAIT_BAT;
                            end else begin
                                w_done       = 1'b1;
                                w_state_next = ST_DONE;
                            end
                        end
                        8'hFC: begin
                            w_done       = 1'b1;
                            w_err        = ERR_DEVICE;
                            w_state_next = ST_FAIL;
                        end
                        8'hFE: begin
                            if (r_retry < RETRY_MAX_C) begin
                                w_retry_inc  = 1'b1;
                                w_state_next = ST_SEND;
                            end else begin
                                w_done       = 1'b1;
                                w_err        = ERR_RETRY;
                                w_state_next = ST_FAIL;
                            end
                        end
                        default: begin
                            w_fwd        = !r_init;
                            w_state_next = ST_WAIT_ACK;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_done       = 1'b1;
                    w_err        = ERR_TIMEOUT;
                    w_state_next = ST_FAIL;
                end else begin
                    w_state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_word_ready && (rx_byte == 8'hAA)) begin
                    w_done       = 1'b1;
                    w_state_next = ST_DONE;
                end else if (rx_word_ready && (rx_byte == 8'hFC)) begin
                    w_done       = 1'b1;
                    w_err        = ERR_DEVICE;
                    w_state_next = ST_FAIL;
                end else if (!rx_word_ready && w_timeout) begin
                    w_done       = 1'b1;
                    w_err        = ERR_TIMEOUT;
                    w_state_next = ST_FAIL;
                end else begin
                    w_state_next = ST_WAIT_BAT;
                end
            end
            ST_DONE, ST_FAIL: begin
                w_init_clr   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, timer, retry and init-phase registers.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
            r_timer <= 20'd0;
            r_retry <= 2'd0;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_timer_clr) begin
                r_timer <= 20'd0;
            end else if (r_timer < TIMEOUT_C) begin
                r_timer <= r_timer + 20'd1;
            end
            if (w_retry_clr) begin
                r_retry <= 2'd0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 2'd1;
            end
            if (w_init_set) begin
                r_init <= 1'b1;
            end else if (w_init_clr) begin
                r_init <= 1'b0;
            end
        end
    end

    // Registered outputs, derived from the upcoming state so they line up with it.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_cmd_ready  <= 1'b0;
            r_cmd_done   <= 1'b0;
            r_cmd_err    <= 2'b00;
            r_tx_send    <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_scan_valid <= 1'b0;
            r_scan_byte  <= 8'h00;
        end else begin
            r_cmd_ready  <= (w_state_next == ST_IDLE);
            r_tx_send    <= (w_state_next == ST_SEND);
            r_cmd_done   <= w_done;
            r_scan_valid <= w_fwd;
            if (w_done) begin
                r_cmd_err <= w_err;
            end
            if (w_load_cmd) begin
                r_tx_byte <= cmd_byte;
            end else if (w_load_init) begin
                r_tx_byte <= 8'hFF;
            end
            if (w_fwd) begin
                r_scan_byte <= rx_byte;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign cmd_done   = r_cmd_done;
    assign cmd_err    = r_cmd_err;
    assign tx_send    = r_tx_send;
    assign tx_byte    = r_tx_byte;
    assign scan_valid = r_scan_valid;
    assign scan_byte  = r_scan_byte;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer: directed commands against a simple PS/2 sender/device model.
module tb_ps2_cmd_sequencer;

    localparam int TO = 100;
    localparam logic [1:0] K_TX = 2'd0;
    localparam logic [1:0] K_SC = 2'd1;
    localparam logic [1:0] K_DN = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic       rx_word_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       cmd_ready;
    logic       cmd_done;
    logic [1:0] cmd_err;
    logic       tx_send;
    logic [7:0] tx_byte;
    logic       scan_valid;
    logic [7:0] scan_byte;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    ev_t sb_q[$];

    ps2_cmd_sequencer #(.MAX_RETRY(3), .TIMEOUT(TO)) dut (
        .ck(ck), .reset(reset), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .tx_send(tx_send), .tx_byte(tx_byte), .tx_busy(tx_busy),
        .rx_word_ready(rx_word_ready), .rx_byte(rx_byte),
        .scan_valid(scan_valid), .scan_byte(scan_byte)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [7:0] val);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual=kind%0d/%0h required=none", kind, val);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                failures++;
                $display("FAIL sb_event actual=kind%0d/%0h required=kind%0d/%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every output event is matched against the next expected event.
    always @(negedge ck) begin
        if (!reset) begin
            if (tx_send)    sb_check(K_TX, tx_byte);
            if (scan_valid) sb_check(K_SC, scan_byte);
            if (cmd_done)   sb_check(K_DN, {6'b000000, cmd_err});
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic wait_ready();
        int i = 0;
        while (!cmd_ready && i < 400) begin step(); i++; end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic issue(input logic [7:0] b);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_byte  = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(output int t);
        int i = 0;
        while (!tx_send && i < 400) begin step(); i++; end
        check("tx_send_wait", {31'd0, tx_send}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_done(output int t);
        int i = 0;
        while (!cmd_done && i < 400) begin step(); i++; end
        check("cmd_done_wait", {31'd0, cmd_done}, 32'd1);
        t = cyc;
    endtask

    task automatic device_busy();
        repeat (3) step();
        tx_busy = 1'b1;
        repeat (50) step();
        tx_busy = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        step();
        rx_word_ready = 1'b1;
        rx_byte       = b;
        step();
        rx_word_ready = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ready"}, {31'd0, cmd_ready}, 32'd0);
        check({name, "_done"}, {31'd0, cmd_done}, 32'd0);
        check({name, "_err"}, {30'd0, cmd_err}, 32'd0);
        check({name, "_send"}, {31'd0, tx_send}, 32'd0);
        check({name, "_txbyte"}, {24'd0, tx_byte}, 32'd0);
        check({name, "_scanv"}, {31'd0, scan_valid}, 32'd0);
        check({name, "_scanb"}, {24'd0, scan_byte}, 32'd0);
    endtask

    task automatic do_init();
        int t;
        push(K_TX, 8'hFF);
        push(K_DN, 8'h00);
        wait_tx(t);
        check("init_txbyte", {24'd0, tx_byte}, 32'hFF);
        device_busy();
        rx(8'hFA);
        rx(8'hAA);
        wait_done(t);
    endtask

    initial begin
        int t0;
        int t1;
        repeat (3) step();
        check_zero("rst");
        reset = 1'b0;
        check("ready_pre", {31'd0, cmd_ready}, 32'd0);
        step();
`ifdef PS2_AUTO_INIT_EN
        check("ready_post_init_hold", {31'd0, cmd_ready}, 32'd0);
        do_init();
`else
        check("ready_post", {31'd0, cmd_ready}, 32'd1);
`endif

        // Plain command with ACK
        push(K_TX, 8'hED);
        push(K_DN, 8'h00);
        issue(8'hED);
        wait_tx(t0);
        device_busy();
        rx(8'hFA);
        wait_done(t1);
        step();
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);

        // Two RESENDs then ACK
        for (int i = 0; i < 3; i++) push(K_TX, 8'hF4);
        push(K_DN, 8'h00);
        issue(8'hF4);
        for (int i = 0; i < 3; i++) begin
            wait_tx(t0);
            device_busy();
            rx((i < 2) ? 8'hFE : 8'hFA);
        end
        wait_done(t1);

        // Scancode forwarding in IDLE and WAIT_ACK
        push(K_SC, 8'h1C);
        rx(8'h1C);
        push(K_TX, 8'hF2);
        push(K_SC, 8'hF0);
        push(K_DN, 8'h00);
        issue(8'hF2);
        wait_tx(t0);
        device_busy();
        rx(8'hF0);
        rx(8'hFA);
        wait_done(t1);

        // Retries exhausted
        for (int i = 0; i < 4; i++) push(K_TX, 8'hF4);
        push(K_DN, 8'h02);
        issue(8'hF4);
        for (int i = 0; i < 4; i++) begin
            wait_tx(t0);
            device_busy();
            rx(8'hFE);
        end
        wait_done(t1);

        // Sender never busy: timeout latency
        push(K_TX, 8'hF3);
        push(K_DN, 8'h01);
        issue(8'hF3);
        wait_tx(t0);
        wait_done(t1);
        check("timeout_latency", t1 - t0, TO + 2);

        // Device ERROR
        push(K_TX, 8'hF5);
        push(K_DN, 8'h03);
        issue(8'hF5);
        wait_tx(t0);
        device_busy();
        rx(8'hFC);
        wait_done(t1);
        step();

        // Reset during WAIT_TX
        push(K_TX, 8'hEE);
        issue(8'hEE);
        wait_tx(t0);
        repeat (3) step();
        tx_busy = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        tx_busy = 1'b0;
        repeat (3) step();
        reset = 1'b0;
`ifdef PS2_AUTO_INIT_EN
        do_init();
`endif
        repeat (20) step();
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
